// File: rtl/ysyx22041405_lsu_if.sv
// ysyx22041405_lsu_if: EX, data-memory and writeback channels of the LSU.
// Build with LSU_MISALIGN_CHECK_EN to add the lsu_misalign writeback flag.
interface ysyx22041405_lsu_if #(parameter int WIDTH = 32);
  logic ex_valid, ex_ready, ex_rf_we;
  logic [WIDTH-1:0] ex_alu_result, ex_store_data;
  logic [4:0] ex_rf_waddr, ex_mem_ctrl;
  logic mem_req_valid, mem_req_ready, mem_req_wen;
  logic [WIDTH-1:0] mem_req_addr, mem_req_wdata;
  logic [WIDTH/8-1:0] mem_req_wstrb;
  logic mem_resp_valid;
  logic [WIDTH-1:0] mem_resp_rdata;
  logic wb_valid, wb_ready, wb_rf_we;
  logic [4:0] wb_rf_waddr;
  logic [WIDTH-1:0] wb_rf_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
  logic lsu_misalign;
`endif
  modport slave (
    input ex_valid, ex_alu_result, ex_store_data, ex_rf_waddr, ex_rf_we, ex_mem_ctrl,
    input mem_req_ready, mem_resp_valid, mem_resp_rdata, wb_ready,
    output ex_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output wb_valid, wb_rf_waddr, wb_rf_we, wb_rf_wdata
`ifdef LSU_MISALIGN_CHECK_EN
    , output lsu_misalign
`endif
  );
  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_rf_waddr, ex_rf_we, ex_mem_ctrl,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, wb_ready,
    input ex_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input wb_valid, wb_rf_waddr, wb_rf_we, wb_rf_wdata
`ifdef LSU_MISALIGN_CHECK_EN
    , input lsu_misalign
`endif
  );
endinterface

// File: rtl/ysyx22041405_lsu.sv
// ysyx22041405_lsu: memory-access stage between EX and WB (IDLE/REQ/WAIT/WB).
// Optional LSU_MISALIGN_CHECK_EN skips the bus for misaligned half/word accesses.
module ysyx22041405_lsu #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  ysyx22041405_lsu_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_addr, r_sdata, r_wdata, w_shift, w_load;
  logic [4:0] r_ctrl, r_waddr, w_amt;
  logic r_we, w_mis, w_take;
  assign w_take = (r_state == IDLE) & io_bus.ex_valid;
`ifdef LSU_MISALIGN_CHECK_EN
  logic r_mis;
  assign w_mis = io_bus.ex_mem_ctrl[4] & (io_bus.ex_mem_ctrl[1] ? |io_bus.ex_alu_result[1:0] :
                 io_bus.ex_mem_ctrl[0] & io_bus.ex_alu_result[0]);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_mis <= 1'b0;
    else if (w_take) r_mis <= w_mis;
  assign io_bus.lsu_misalign = r_mis & (r_state == WB);
`else
  assign w_mis = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (io_bus.ex_valid) w_next = (!io_bus.ex_mem_ctrl[4] || w_mis) ? WB : REQ;
      REQ: if (io_bus.mem_req_ready) w_next = r_ctrl[3] ? WB : WAIT;
      WAIT: if (io_bus.mem_resp_valid) w_next = WB;
      WB: if (io_bus.wb_ready) w_next = IDLE;
    endcase
  end
  // Lane select: words ignore addr[1:0], halves ignore addr[0].
  assign w_amt = r_ctrl[1] ? 5'd0 : {r_addr[1], r_addr[0] & ~r_ctrl[0], 3'b000};
  assign w_shift = io_bus.mem_resp_rdata >> w_amt;
  assign w_load = r_ctrl[1] ? w_shift :
                  r_ctrl[0] ? {{16{~r_ctrl[2] & w_shift[15]}}, w_shift[15:0]} :
                  {{24{~r_ctrl[2] & w_shift[7]}}, w_shift[7:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_addr <= '0;
      r_sdata <= '0;
      r_wdata <= '0;
      r_ctrl <= '0;
      r_waddr <= '0;
      r_we <= 1'b0;
    end else if (w_take) begin
      r_addr <= io_bus.ex_alu_result;
      r_sdata <= io_bus.ex_store_data;
      r_wdata <= io_bus.ex_alu_result;
      r_ctrl <= io_bus.ex_mem_ctrl;
      r_waddr <= io_bus.ex_rf_waddr;
      r_we <= io_bus.ex_rf_we & ~(io_bus.ex_mem_ctrl[4] & (io_bus.ex_mem_ctrl[3] | w_mis));
    end else if (r_state == WAIT && io_bus.mem_resp_valid) r_wdata <= w_load;
  assign io_bus.ex_ready = r_state == IDLE;
  assign io_bus.mem_req_valid = r_state == REQ;
  assign io_bus.mem_req_addr = {r_addr[WIDTH-1:2], 2'b00};
  assign io_bus.mem_req_wen = r_ctrl[3];
  assign io_bus.mem_req_wdata = r_ctrl[1] ? r_sdata : r_ctrl[0] ? {2{r_sdata[15:0]}} : {4{r_sdata[7:0]}};
  assign io_bus.mem_req_wstrb = !r_ctrl[3] ? 4'b0000 : r_ctrl[1] ? 4'b1111 :
                                r_ctrl[0] ? 4'b0011 << {r_addr[1], 1'b0} : 4'b0001 << r_addr[1:0];
  assign io_bus.wb_valid = r_state == WB;
  assign io_bus.wb_rf_waddr = r_waddr;
  assign io_bus.wb_rf_we = r_we;
  assign io_bus.wb_rf_wdata = r_wdata;
endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// tb_ysyx22041405_lsu: scoreboard bench for the LSU with a scripted memory responder.
module tb_ysyx22041405_lsu;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  ysyx22041405_lsu_if bus();
  ysyx22041405_lsu dut (.clk(clk), .rst(rst), .io_bus(bus));

  typedef struct packed {logic [4:0] waddr; logic we; logic [31:0] wdata;} wb_t;
  typedef struct packed {logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  wb_t wb_q[$];
  req_t req_q[$];
  wb_t mon_e;
  req_t rsp_e, rsp_s;
  int n_vec = 0, n_err = 0, wb_hs = 0;
  int req_stall = 0, resp_dly = 1;
  logic [31:0] rdata_v = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic misal(input logic [31:0] a, input logic [4:0] c);
`ifdef LSU_MISALIGN_CHECK_EN
    return c[4] && ((c[1:0] == 2'b01 && a[0]) || (c[1] && a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic req_t req_model(input logic [31:0] a, input logic [31:0] d, input logic [4:0] c);
    req_t r;
    r.addr = {a[31:2], 2'b00};
    r.wen = c[3];
    case (c[1:0])
      2'b00: begin r.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]}; r.wstrb = 4'b0001 << a[1:0]; end
      2'b01: begin r.wdata = {d[15:0], d[15:0]}; r.wstrb = 4'b0011 << {a[1], 1'b0}; end
      default: begin r.wdata = d; r.wstrb = 4'b1111; end
    endcase
    if (!c[3]) r.wstrb = 4'b0000;
    return r;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] a, input logic [4:0] c, input logic [31:0] rd);
    int sh;
    logic [7:0] b;
    logic [15:0] h;
    case (c[1:0])
      2'b00: begin sh = int'(a[1:0]); b = rd[8*sh +: 8]; return c[2] ? {24'h0, b} : {{24{b[7]}}, b}; end
      2'b01: begin sh = int'(a[1]); h = rd[16*sh +: 16]; return c[2] ? {16'h0, h} : {{16{h[15]}}, h}; end
      default: return rd;
    endcase
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd, input logic we,
                      input logic [4:0] c, input logic [31:0] rdata);
    wb_t w;
    logic m;
    m = misal(a, c);
    @(negedge clk);
    check("ex_ready_idle", bus.ex_ready, 1);
    rdata_v = rdata;
    if (c[4] && !m) req_q.push_back(req_model(a, d, c));
    w.waddr = rd;
    w.we = we & !(c[4] && c[3]) & !m;
    w.wdata = (c[4] && !c[3] && !m) ? load_model(a, c, rdata) : a;
    wb_q.push_back(w);
    bus.ex_valid = 1'b1;
    bus.ex_alu_result = a;
    bus.ex_store_data = d;
    bus.ex_rf_waddr = rd;
    bus.ex_rf_we = we;
    bus.ex_mem_ctrl = c;
    @(posedge clk);
    #1 bus.ex_valid = 1'b0;
  endtask

  task automatic wait_wb(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      check("ex_ready_busy", bus.ex_ready, 0);
    end while (!bus.wb_valid && k < 60);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd, input logic we,
                     input logic [4:0] c, input logic [31:0] rdata, input int lat);
    int k;
    send(a, d, rd, we, c, rdata);
    wait_wb(k);
    check("latency", k, lat);
    @(posedge clk);
    @(negedge clk);
    check("wb_fall", bus.wb_valid, 0);
  endtask

  always @(negedge clk)
    if (rst && bus.wb_valid && bus.wb_ready) begin
      if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
      else begin
        mon_e = wb_q.pop_front();
        wb_hs++;
        check("wb_waddr", bus.wb_rf_waddr, mon_e.waddr);
        check("wb_we", bus.wb_rf_we, mon_e.we);
        if (mon_e.we) check("wb_wdata", bus.wb_rf_wdata, mon_e.wdata);
      end
    end

  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.mem_req_valid) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 1, 0);
          continue;
        end
        rsp_e = req_q.pop_front();
        rsp_s = {bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wstrb};
        for (int i = 0; i < req_stall; i++) begin
          @(negedge clk);
          check("req_hold_valid", bus.mem_req_valid, 1);
          check("req_hold_addr", bus.mem_req_addr, rsp_s.addr);
          check("req_hold_wdata", bus.mem_req_wdata, rsp_s.wdata);
          check("req_hold_wstrb", bus.mem_req_wstrb, rsp_s.wstrb);
        end
        check("req_addr", bus.mem_req_addr, rsp_e.addr);
        check("req_wen", bus.mem_req_wen, rsp_e.wen);
        if (rsp_e.wen) check("req_wdata", bus.mem_req_wdata, rsp_e.wdata);
        check("req_wstrb", bus.mem_req_wstrb, rsp_e.wstrb);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        if (!rsp_e.wen) begin
          repeat (resp_dly - 1) @(negedge clk);
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = rdata_v;
          @(negedge clk);
          bus.mem_resp_valid = 1'b0;
          bus.mem_resp_rdata = 32'hDEAD_BEEF;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, h0;
    logic [31:0] sd;
    bus.ex_valid = 1'b0;
    bus.ex_alu_result = '0;
    bus.ex_store_data = '0;
    bus.ex_rf_waddr = '0;
    bus.ex_rf_we = 1'b0;
    bus.ex_mem_ctrl = '0;
    bus.wb_ready = 1'b1;
    #1;
    check("rst_ex_ready", bus.ex_ready, 1);
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_req_addr", bus.mem_req_addr, 0);
    check("rst_req_wstrb", bus.mem_req_wstrb, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_wdata", bus.wb_rf_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // ctrl: [4] mem_en [3] store [2] unsigned [1:0] size
    run(32'h1234_5678, 32'h0, 5'd5, 1'b1, 5'b00000, 32'h0, 1);
    run(32'h8000_0003, 32'h0, 5'd3, 1'b1, 5'b10000, 32'h80FF_0000, 3);
    run(32'h8000_0003, 32'h0, 5'd4, 1'b1, 5'b10100, 32'h80FF_0000, 3);
    run(32'h8000_0102, 32'hAAAA_BEEF, 5'd6, 1'b1, 5'b11001, 32'h0, 2);
    run(32'h8000_0201, 32'h1122_33C4, 5'd7, 1'b1, 5'b11000, 32'h0, 2);
    run(32'h8000_0300, 32'hCAFE_F00D, 5'd8, 1'b1, 5'b11010, 32'h0, 2);
    run(32'h8000_0402, 32'h0, 5'd10, 1'b1, 5'b10001, 32'h8001_7FFF, 3);
    run(32'h8000_0400, 32'h0, 5'd11, 1'b1, 5'b10001, 32'h8001_7FFF, 3);
    run(32'h8000_0404, 32'h0, 5'd12, 1'b1, 5'b10010, 32'h89AB_CDEF, 3);
    run(32'h8000_0502, 32'h0, 5'd13, 1'b0, 5'b10001, 32'h1234_5678, 3);
    for (int i = 0; i < 4; i++) begin
      sd = $urandom;
      run(sd, 32'h0, 5'($urandom_range(1, 31)), 1'b1, 5'b00000, 32'h0, 1);
    end
    // bus stall, late response, then writeback stall
    req_stall = 3;
    resp_dly = 2;
    @(posedge clk);
    #1 bus.wb_ready = 1'b0;
    h0 = wb_hs;
    send(32'h8000_0002, 32'h0, 5'd9, 1'b1, 5'b10101, 32'hCAFE_1234);
    wait_wb(k);
    check("stall_latency", k, 7);
    sd = bus.wb_rf_wdata;
    check("stall_wb_wdata", sd, 32'h0000_CAFE);
    @(posedge clk);
    @(negedge clk);
    check("wb_hold_valid", bus.wb_valid, 1);
    check("wb_hold_wdata", bus.wb_rf_wdata, sd);
    check("wb_hold_ex_ready", bus.ex_ready, 0);
    @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_wb_fall", bus.wb_valid, 0);
    check("stall_one_hs", wb_hs - h0, 1);
    req_stall = 0;
    resp_dly = 6;
    // reset while waiting for the load response
    send(32'h8000_0010, 32'h0, 5'd14, 1'b1, 5'b10010, 32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_waiting", bus.wb_valid | bus.mem_req_valid, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req_valid", bus.mem_req_valid, 0);
    check("async_rst_wb_valid", bus.wb_valid, 0);
    check("async_rst_ex_ready", bus.ex_ready, 1);
    wb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_wb", bus.wb_valid, 0);
    end
    resp_dly = 1;
    run(32'h0BAD_F00D, 32'h0, 5'd15, 1'b1, 5'b00000, 32'h0, 1);
    // misaligned word load
    h0 = wb_hs;
`ifdef LSU_MISALIGN_CHECK_EN
    send(32'h8000_0002, 32'h0, 5'd16, 1'b1, 5'b10010, 32'h1357_9BDF);
    wait_wb(k);
    check("misalign_latency", k, 1);
    check("misalign_flag", bus.lsu_misalign, 1);
    @(posedge clk);
    @(negedge clk);
    check("misalign_flag_fall", bus.lsu_misalign, 0);
`else
    run(32'h8000_0002, 32'h0, 5'd16, 1'b1, 5'b10010, 32'h1357_9BDF, 3);
`endif
    check("misalign_one_hs", wb_hs - h0, 1);
    repeat (3) @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
